// File: rtl/axi_sram_slave_pkg.sv
// Shared definitions for the AXI3 SRAM slave: response codes and
// one-hot state encodings for the read and write engines.
package axi_sram_slave_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        R_IDLE  = 2'b01,
        R_BURST = 2'b10
    } r_state_t;

    typedef enum logic [2:0] {
        W_IDLE = 3'b001,
        W_DATA = 3'b010,
        W_RESP = 3'b100
    } w_state_t;

    function automatic logic [1:0] resp_of(input logic err);
        return err ? RESP_SLVERR : RESP_OKAY;
    endfunction

endpackage

// File: rtl/sram_bytewrite.sv
// Word-addressed 32-bit memory with a registered read port
// and a byte-enable write port.
module sram_bytewrite #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [31:0]       rd_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [3:0]        wr_be,
    input  logic [31:0]       wr_data
);

    logic [31:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[wr_addr][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    // Same-cycle read of a word being written returns the old value.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by on-chip SRAM; independent read and write
// engines, one outstanding transaction per direction.
module axi_sram_slave
    import axi_sram_slave_pkg::*;
#(
    parameter int ADDR_W = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  axi_arid,
    input  logic [31:0] axi_araddr,
    input  logic [7:0]  axi_arlen,
    input  logic [2:0]  axi_arsize,
    input  logic [1:0]  axi_arburst,
    input  logic [1:0]  axi_arlock,
    input  logic [3:0]  axi_arcache,
    input  logic [2:0]  axi_arprot,
    input  logic        axi_arvalid,
    output logic        axi_arready,
    output logic [3:0]  axi_rid,
    output logic [31:0] axi_rdata,
    output logic [1:0]  axi_rresp,
    output logic        axi_rlast,
    output logic        axi_rvalid,
    input  logic        axi_rready,
    input  logic [3:0]  axi_awid,
    input  logic [31:0] axi_awaddr,
    input  logic [7:0]  axi_awlen,
    input  logic [2:0]  axi_awsize,
    input  logic [1:0]  axi_awburst,
    input  logic [1:0]  axi_awlock,
    input  logic [3:0]  axi_awcache,
    input  logic [2:0]  axi_awprot,
    input  logic        axi_awvalid,
    output logic        axi_awready,
    input  logic [3:0]  axi_wid,
    input  logic [31:0] axi_wdata,
    input  logic [3:0]  axi_wstrb,
    input  logic        axi_wlast,
    input  logic        axi_wvalid,
    output logic        axi_wready,
    output logic [3:0]  axi_bid,
    output logic [1:0]  axi_bresp,
    output logic        axi_bvalid,
    input  logic        axi_bready
);

    localparam logic [ADDR_W-1:0] IDX_ONE = ADDR_W'(1);

    r_state_t          r_state;
    w_state_t          w_state;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] w_idx;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic [7:0]        w_len;
    logic [7:0]        w_cnt;
    logic              w_err;
    logic              ar_hs;
    logic              r_hs;
    logic              r_end;
    logic              w_end;
    logic              w_bad;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;

    assign axi_arready = (r_state == R_IDLE);
    assign axi_rvalid  = (r_state == R_BURST);
    assign axi_rresp   = RESP_OKAY;
    assign axi_awready = (w_state == W_IDLE);
    assign axi_wready  = (w_state == W_DATA);
    assign axi_bvalid  = (w_state == W_RESP);

    assign ar_hs = axi_arready && axi_arvalid;
    assign r_hs  = axi_rvalid && axi_rready;
    assign r_end = (r_cnt == r_len);
    assign w_end = (w_cnt == w_len);
    assign w_bad = (axi_wlast != w_end);

    // Prefetch the next word only when the current beat is accepted.
    assign rd_en   = !reset && (ar_hs || (r_hs && !r_end));
    assign rd_addr = ar_hs ? axi_araddr[ADDR_W+1:2] : r_idx + IDX_ONE;
    assign wr_en   = !reset && axi_wready && axi_wvalid;

    sram_bytewrite #(
        .ADDR_W(ADDR_W)
    ) u_sram (
        .clk    (clk),
        .reset  (reset),
        .rd_en  (rd_en),
        .rd_addr(rd_addr),
        .rd_data(axi_rdata),
        .wr_en  (wr_en),
        .wr_addr(w_idx),
        .wr_be  (axi_wstrb),
        .wr_data(axi_wdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= R_IDLE;
            axi_rid   <= '0;
            axi_rlast <= 1'b0;
            r_len     <= '0;
            r_cnt     <= '0;
            r_idx     <= '0;
        end else begin
            unique case (r_state)
                R_IDLE: begin
                    if (axi_arvalid) begin
                        r_state   <= R_BURST;
                        axi_rid   <= axi_arid;
                        r_len     <= axi_arlen;
                        r_cnt     <= '0;
                        r_idx     <= axi_araddr[ADDR_W+1:2];
                        axi_rlast <= (axi_arlen == 8'd0);
                    end
                end
                R_BURST: begin
                    if (axi_rready) begin
                        if (r_end) begin
                            r_state   <= R_IDLE;
                            axi_rlast <= 1'b0;
                        end else begin
                            r_cnt     <= r_cnt + 8'd1;
                            r_idx     <= r_idx + IDX_ONE;
                            axi_rlast <= (r_cnt + 8'd1 == r_len);
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    // Burst length alone ends the data phase; wlast only grades bresp.
    always_ff @(posedge clk) begin
        if (reset) begin
            w_state   <= W_IDLE;
            axi_bid   <= '0;
            axi_bresp <= RESP_OKAY;
            w_len     <= '0;
            w_cnt     <= '0;
            w_idx     <= '0;
            w_err     <= 1'b0;
        end else begin
            unique case (w_state)
                W_IDLE: begin
                    if (axi_awvalid) begin
                        w_state <= W_DATA;
                        axi_bid <= axi_awid;
                        w_len   <= axi_awlen;
                        w_cnt   <= '0;
                        w_idx   <= axi_awaddr[ADDR_W+1:2];
                        w_err   <= 1'b0;
                    end
                end
                W_DATA: begin
                    if (axi_wvalid) begin
                        if (w_end) begin
                            w_state   <= W_RESP;
                            axi_bresp <= resp_of(w_err || w_bad);
                        end else begin
                            w_cnt <= w_cnt + 8'd1;
                            w_idx <= w_idx + IDX_ONE;
                            w_err <= w_err || w_bad;
                        end
                    end
                end
                W_RESP: begin
                    if (axi_bready) begin
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    logic unused_in;
    assign unused_in = ^{axi_arsize, axi_arburst, axi_arlock,
                         axi_arcache, axi_arprot, axi_awsize,
                         axi_awburst, axi_awlock, axi_awcache,
                         axi_awprot, axi_wid,
                         axi_araddr[31:ADDR_W+2], axi_araddr[1:0],
                         axi_awaddr[31:ADDR_W+2], axi_awaddr[1:0]};

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized bench for axi_sram_slave against a word-array
// memory model with per-byte validity tracking.
module tb_axi_sram_slave;

    localparam int AW    = 12;
    localparam int DEPTH = 1 << AW;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  axi_arid;
    logic [31:0] axi_araddr;
    logic [7:0]  axi_arlen;
    logic [2:0]  axi_arsize;
    logic [1:0]  axi_arburst;
    logic [1:0]  axi_arlock;
    logic [3:0]  axi_arcache;
    logic [2:0]  axi_arprot;
    logic        axi_arvalid;
    logic        axi_arready;
    logic [3:0]  axi_rid;
    logic [31:0] axi_rdata;
    logic [1:0]  axi_rresp;
    logic        axi_rlast;
    logic        axi_rvalid;
    logic        axi_rready;
    logic [3:0]  axi_awid;
    logic [31:0] axi_awaddr;
    logic [7:0]  axi_awlen;
    logic [2:0]  axi_awsize;
    logic [1:0]  axi_awburst;
    logic [1:0]  axi_awlock;
    logic [3:0]  axi_awcache;
    logic [2:0]  axi_awprot;
    logic        axi_awvalid;
    logic        axi_awready;
    logic [3:0]  axi_wid;
    logic [31:0] axi_wdata;
    logic [3:0]  axi_wstrb;
    logic        axi_wlast;
    logic        axi_wvalid;
    logic        axi_wready;
    logic [3:0]  axi_bid;
    logic [1:0]  axi_bresp;
    logic        axi_bvalid;
    logic        axi_bready;

    always #5 clk = ~clk;

    axi_sram_slave #(.ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .axi_arid(axi_arid), .axi_araddr(axi_araddr),
        .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
        .axi_arburst(axi_arburst), .axi_arlock(axi_arlock),
        .axi_arcache(axi_arcache), .axi_arprot(axi_arprot),
        .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rid(axi_rid), .axi_rdata(axi_rdata),
        .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
        .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
        .axi_awid(axi_awid), .axi_awaddr(axi_awaddr),
        .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
        .axi_awburst(axi_awburst), .axi_awlock(axi_awlock),
        .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
        .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
        .axi_wid(axi_wid), .axi_wdata(axi_wdata),
        .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
        .axi_bid(axi_bid), .axi_bresp(axi_bresp),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
    );

    logic [31:0] mem_m [DEPTH];
    logic [3:0]  known [DEPTH];
    logic [31:0] wbuf  [256];
    logic [3:0]  sbuf  [256];
    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'(a[AW+1:2]);
    endfunction

    function automatic logic [31:0] bmask(input logic [3:0] k);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{k[i]}};
        return m;
    endfunction

    function automatic void model_write(input int idx, input logic [31:0] d,
                                        input logic [3:0] s);
        for (int i = 0; i < 4; i++) begin
            if (s[i]) begin
                mem_m[idx][8*i +: 8] = d[8*i +: 8];
                known[idx][i] = 1'b1;
            end
        end
    endfunction

    task automatic axi_write(input logic [3:0] id, input logic [31:0] addr,
                             input int len, input int wl_beat, input bit gaps);
        int t;
        int idx;
        int dly;
        @(negedge clk);
        axi_awid    = id;
        axi_awaddr  = addr;
        axi_awlen   = 8'(len);
        axi_awsize  = 3'($urandom);
        axi_awburst = 2'($urandom);
        axi_awlock  = 2'($urandom);
        axi_awcache = 4'($urandom);
        axi_awprot  = 3'($urandom);
        axi_awvalid = 1'b1;
        t = 0;
        while (!axi_awready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("awready", 32'(axi_awready), 32'd1);
        @(negedge clk);
        axi_awvalid = 1'b0;
        check("wready_after_aw", 32'(axi_wready), 32'd1);
        check("awready_busy", 32'(axi_awready), 32'd0);
        idx = widx(addr);
        for (int b = 0; b <= len; b++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                axi_wvalid = 1'b0;
                @(negedge clk);
            end
            axi_wvalid = 1'b1;
            axi_wid    = 4'($urandom);
            axi_wdata  = wbuf[b];
            axi_wstrb  = sbuf[b];
            axi_wlast  = (b == wl_beat);
            check("wready", 32'(axi_wready), 32'd1);
            model_write(idx, wbuf[b], sbuf[b]);
            idx = (idx + 1) % DEPTH;
            @(negedge clk);
        end
        axi_wvalid = 1'b0;
        axi_wlast  = 1'b0;
        check("wready_off", 32'(axi_wready), 32'd0);
        dly = int'($urandom_range(0, 2));
        for (int d = 0; d <= dly; d++) begin
            check("bvalid", 32'(axi_bvalid), 32'd1);
            check("bid", 32'(axi_bid), 32'(id));
            check("bresp", 32'(axi_bresp),
                  (wl_beat == len) ? 32'd0 : 32'd2);
            if (d < dly) @(negedge clk);
        end
        axi_bready = 1'b1;
        @(negedge clk);
        axi_bready = 1'b0;
        check("bvalid_drop", 32'(axi_bvalid), 32'd0);
        check("awready_back", 32'(axi_awready), 32'd1);
    endtask

    // mode 0: rready held high, 1: toggling 1/0, 2: random
    task automatic axi_read(input logic [3:0] id, input logic [31:0] addr,
                            input int len, input int mode);
        int t;
        int idx;
        int beat;
        logic rr;
        logic tog;
        @(negedge clk);
        axi_arid    = id;
        axi_araddr  = addr;
        axi_arlen   = 8'(len);
        axi_arsize  = 3'($urandom);
        axi_arburst = 2'($urandom);
        axi_arlock  = 2'($urandom);
        axi_arcache = 4'($urandom);
        axi_arprot  = 3'($urandom);
        axi_arvalid = 1'b1;
        t = 0;
        while (!axi_arready && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("arready", 32'(axi_arready), 32'd1);
        @(negedge clk);
        axi_arvalid = 1'b0;
        check("arready_busy", 32'(axi_arready), 32'd0);
        idx  = widx(addr);
        beat = 0;
        tog  = 1'b1;
        t    = 0;
        while (beat <= len && t < 2000) begin
            rr = (mode == 0) ? 1'b1 :
                 (mode == 1) ? tog : 1'($urandom_range(0, 1));
            tog = !tog;
            axi_rready = rr;
            check("rvalid", 32'(axi_rvalid), 32'd1);
            check("rdata", axi_rdata & bmask(known[idx]),
                  mem_m[idx] & bmask(known[idx]));
            check("rlast", 32'(axi_rlast), 32'(beat == len));
            check("rid", 32'(axi_rid), 32'(id));
            check("rresp", 32'(axi_rresp), 32'd0);
            if (rr) begin
                beat++;
                idx = (idx + 1) % DEPTH;
            end
            @(negedge clk);
            t++;
        end
        axi_rready = 1'b0;
        check("read_done", 32'(beat), 32'(len + 1));
        check("rvalid_drop", 32'(axi_rvalid), 32'd0);
        check("arready_back", 32'(axi_arready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] old;
        logic [31:0] wa;
        int len;
        int wl;
        int t;
        for (int i = 0; i < DEPTH; i++) begin
            mem_m[i] = '0;
            known[i] = '0;
        end
        reset = 1'b1;
        axi_arid = '0; axi_araddr = '0; axi_arlen = '0;
        axi_arsize = '0; axi_arburst = '0; axi_arlock = '0;
        axi_arcache = '0; axi_arprot = '0; axi_arvalid = 1'b0;
        axi_rready = 1'b0;
        axi_awid = '0; axi_awaddr = '0; axi_awlen = '0;
        axi_awsize = '0; axi_awburst = '0; axi_awlock = '0;
        axi_awcache = '0; axi_awprot = '0; axi_awvalid = 1'b0;
        axi_wid = '0; axi_wdata = '0; axi_wstrb = '0;
        axi_wlast = 1'b0; axi_wvalid = 1'b0; axi_bready = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_arready", 32'(axi_arready), 32'd1);
        check("rst_awready", 32'(axi_awready), 32'd1);
        check("rst_rvalid", 32'(axi_rvalid), 32'd0);
        check("rst_rlast", 32'(axi_rlast), 32'd0);
        check("rst_wready", 32'(axi_wready), 32'd0);
        check("rst_bvalid", 32'(axi_bvalid), 32'd0);
        check("rst_rdata", axi_rdata, 32'd0);
        check("rst_ids", {24'd0, axi_rid, axi_bid}, 32'd0);
        check("rst_resps", {28'd0, axi_rresp, axi_bresp}, 32'd0);

        wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
        axi_write(4'h3, 32'h100, 0, 0, 1'b0);
        axi_read(4'h5, 32'h100, 0, 0);

        wbuf[0] = 32'h11; wbuf[1] = 32'h22;
        wbuf[2] = 32'h33; wbuf[3] = 32'h44;
        for (int i = 0; i < 4; i++) sbuf[i] = 4'hF;
        axi_write(4'h7, 32'h200, 3, 3, 1'b0);
        axi_read(4'h9, 32'h200, 3, 1);

        wbuf[0] = 32'hFFFFFFFF; sbuf[0] = 4'hF;
        axi_write(4'h1, 32'h300, 0, 0, 1'b0);
        wbuf[0] = 32'h0000AB00; sbuf[0] = 4'b0010;
        axi_write(4'h2, 32'h300, 0, 0, 1'b0);
        axi_read(4'h4, 32'h300, 0, 0);
        check("byte_merge", axi_rdata, 32'hFFFFABFF);

        for (int i = 0; i < 4; i++) begin
            wbuf[i] = 32'hA000_0000 + 32'(i);
            sbuf[i] = 4'hF;
        end
        axi_write(4'hA, 32'h400, 3, 1, 1'b0);
        axi_write(4'hB, 32'h410, 0, 0, 1'b0);
        axi_read(4'hC, 32'h400, 3, 2);

        wbuf[0] = 32'hCAFE0001; wbuf[1] = 32'hCAFE0002;
        sbuf[0] = 4'hF; sbuf[1] = 4'hF;
        axi_write(4'hD, 32'h3FFC, 1, 1, 1'b0);
        axi_read(4'hE, 32'h3FFC, 1, 0);
        axi_read(4'hF, 32'h0, 0, 0);

        wbuf[0] = 32'h12345678; sbuf[0] = 4'hF;
        axi_write(4'h1, 32'h600, 0, 0, 1'b0);
        old = mem_m[widx(32'h600)];
        @(negedge clk);
        axi_awid = 4'h6; axi_awaddr = 32'h600; axi_awlen = 8'd0;
        axi_awvalid = 1'b1;
        @(negedge clk);
        axi_awvalid = 1'b0;
        check("col_wready", 32'(axi_wready), 32'd1);
        axi_arid = 4'h8; axi_araddr = 32'h600; axi_arlen = 8'd0;
        axi_arvalid = 1'b1;
        axi_wdata = 32'hCAFEF00D; axi_wstrb = 4'hF;
        axi_wlast = 1'b1; axi_wvalid = 1'b1;
        axi_rready = 1'b1;
        check("col_arready", 32'(axi_arready), 32'd1);
        @(negedge clk);
        axi_arvalid = 1'b0;
        axi_wvalid = 1'b0;
        axi_wlast = 1'b0;
        model_write(widx(32'h600), 32'hCAFEF00D, 4'hF);
        check("col_rvalid", 32'(axi_rvalid), 32'd1);
        check("col_rdata_old", axi_rdata, old);
        check("col_bvalid", 32'(axi_bvalid), 32'd1);
        check("col_bresp", 32'(axi_bresp), 32'd0);
        axi_bready = 1'b1;
        @(negedge clk);
        axi_bready = 1'b0;
        axi_rready = 1'b0;
        check("col_rvalid_drop", 32'(axi_rvalid), 32'd0);
        axi_read(4'h2, 32'h600, 0, 0);

        for (int i = 0; i < 8; i++) begin
            wbuf[i] = $urandom;
            sbuf[i] = 4'hF;
        end
        axi_write(4'h3, 32'h500, 7, 7, 1'b0);
        @(negedge clk);
        axi_arid = 4'h4; axi_araddr = 32'h500; axi_arlen = 8'd7;
        axi_arvalid = 1'b1;
        @(negedge clk);
        axi_arvalid = 1'b0;
        axi_rready = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        axi_rready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        check("mid_rst_rvalid", 32'(axi_rvalid), 32'd0);
        check("mid_rst_arready", 32'(axi_arready), 32'd1);
        check("mid_rst_rdata", axi_rdata, 32'd0);
        axi_read(4'h5, 32'h500, 7, 2);

        for (int n = 0; n < 40; n++) begin
            len = int'($urandom_range(0, 7));
            wa  = $urandom;
            wl  = ($urandom_range(0, 4) == 0) ?
                  int'($urandom_range(0, len + 1)) : len;
            for (int i = 0; i <= len; i++) begin
                wbuf[i] = $urandom;
                sbuf[i] = ($urandom_range(0, 2) == 0) ?
                          4'($urandom) : 4'hF;
            end
            axi_write(4'($urandom), wa, len, wl, 1'($urandom));
            t = int'($urandom_range(0, 3));
            axi_read(4'($urandom), wa + 32'(4 * t),
                     int'($urandom_range(0, 7)),
                     int'($urandom_range(0, 2)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
